// File: rtl/gate_bist_if.sv
// Harness/gate-side signal bundle for gate_bist_ctrl.
// i_/o_ prefixes are from the controller's point of view.
interface gate_bist_if #(
  parameter int unsigned N_IN = 2
);
  logic            i_start;
  logic [2:0]      i_gate_op;
  logic            i_dut_out;
  logic [N_IN-1:0] o_stim;
  logic            o_busy;
  logic            o_done;
  logic            o_pass;
  logic [N_IN:0]   o_fail_count;
  logic [N_IN-1:0] o_first_fail_vec;
  logic            o_first_fail_valid;

  // Controller side
  modport master (
    input  i_start, i_gate_op, i_dut_out,
    output o_stim, o_busy, o_done, o_pass, o_fail_count,
           o_first_fail_vec, o_first_fail_valid
  );

  // Harness / gate side
  modport slave (
    output i_start, i_gate_op, i_dut_out,
    input  o_stim, o_busy, o_done, o_pass, o_fail_count,
           o_first_fail_vec, o_first_fail_valid
  );
endinterface

// File: rtl/gate_bist_ctrl.sv
// Exhaustive BIST controller for a single-output combinational gate.
// Walks stim through 0..2^N_IN-1, holds each vector SETTLE cycles, then
// compares dut_out with the expected function and accumulates results.
module gate_bist_ctrl #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  gate_bist_if.master bus
);

  localparam int unsigned FW       = N_IN + 1;
  localparam logic [3:0]  CNT_INIT = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic [2:0]      r_op;
  logic [N_IN-1:0] r_stim;
  logic [N_IN-1:0] r_ffv;
  logic            r_ffvalid;
  logic [FW-1:0]   r_fail;
  logic            r_pass;

  logic            w_expected;
  logic            w_mismatch;
  logic            w_last;
  logic [FW-1:0]   w_fail_nxt;
  logic            w_busy;
  logic            w_done;

  // Expected gate output for the current vector
  always_comb begin
    w_expected = 1'b0;
    case (r_op)
      3'd0:    w_expected = ~r_stim[0];
      3'd1:    w_expected =  r_stim[0];
      3'd2:    w_expected =  &r_stim;
      3'd3:    w_expected =  |r_stim;
      3'd4:    w_expected = ~&r_stim;
      3'd5:    w_expected = ~|r_stim;
      3'd6:    w_expected =  ^r_stim;
      3'd7:    w_expected = ~^r_stim;
      default: w_expected = 1'b0;
    endcase
  end

  assign w_mismatch = (bus.i_dut_out != w_expected);
  assign w_last     = &r_stim;
  // Count including the current CHECK so pass is already final in DONE
  assign w_fail_nxt = r_fail + FW'(w_mismatch);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and status decode
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_state_nxt = S_WAIT;
      S_WAIT: begin
        w_busy = 1'b1;
        if (r_cnt == 4'd0) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        w_busy      = 1'b1;
        w_state_nxt = w_last ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: vector stepping, settle counter and result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_op      <= '0;
      r_stim    <= '0;
      r_ffv     <= '0;
      r_ffvalid <= 1'b0;
      r_fail    <= '0;
      r_pass    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_op      <= bus.i_gate_op;
            r_stim    <= '0;
            r_cnt     <= CNT_INIT;
            r_ffv     <= '0;
            r_ffvalid <= 1'b0;
            r_fail    <= '0;
            r_pass    <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        S_CHECK: begin
          if (w_mismatch) begin
            r_fail <= w_fail_nxt;
            if (!r_ffvalid) begin
              r_ffv     <= r_stim;
              r_ffvalid <= 1'b1;
            end
          end
          if (w_last) begin
            r_pass <= (w_fail_nxt == '0);
          end else begin
            r_stim <= r_stim + N_IN'(1);
            r_cnt  <= CNT_INIT;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_stim             = r_stim;
  assign bus.o_busy             = w_busy;
  assign bus.o_done             = w_done;
  assign bus.o_pass             = r_pass;
  assign bus.o_fail_count       = r_fail;
  assign bus.o_first_fail_vec   = r_ffv;
  assign bus.o_first_fail_valid = r_ffvalid;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl: two instances (N_IN=2/SETTLE=2 and
// N_IN=1/SETTLE=1) driven by a table of runs plus hand-written sequences.
module tb_gate_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2_n, rst1_n;
  int   errors = 0;
  int   checks = 0;

  gate_bist_if #(.N_IN(2)) bus2();
  gate_bist_if #(.N_IN(1)) bus1();

  gate_bist_ctrl #(.N_IN(2), .SETTLE(2)) u_dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));
  gate_bist_ctrl #(.N_IN(1), .SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst1_n), .bus(bus1));

  // Behavioural gates under test: 0 inverter, 1 OR gate, 2 stuck-at-0
  int mode2 = 0;
  assign bus2.i_dut_out = (mode2 == 0) ? ~bus2.o_stim[0] :
                          (mode2 == 1) ?  |bus2.o_stim   : 1'b0;
  assign bus1.i_dut_out = ~bus1.o_stim[0];

  // Selected-instance view, widened to the N_IN=2 sizes
  logic       cur1 = 1'b0;
  logic       w_done, w_busy, w_pass, w_ffvalid;
  logic [1:0] w_stim, w_ffv;
  logic [2:0] w_fail;
  assign w_done    = cur1 ? bus1.o_done             : bus2.o_done;
  assign w_busy    = cur1 ? bus1.o_busy             : bus2.o_busy;
  assign w_pass    = cur1 ? bus1.o_pass             : bus2.o_pass;
  assign w_ffvalid = cur1 ? bus1.o_first_fail_valid : bus2.o_first_fail_valid;
  assign w_stim    = cur1 ? {1'b0, bus1.o_stim}           : bus2.o_stim;
  assign w_ffv     = cur1 ? {1'b0, bus1.o_first_fail_vec} : bus2.o_first_fail_vec;
  assign w_fail    = cur1 ? {1'b0, bus1.o_fail_count}     : bus2.o_fail_count;

  typedef struct {
    bit       cfg1;     // 1: N_IN=1 instance
    int       mode;     // gate model for the N_IN=2 instance
    bit [2:0] op;
    int       cycles;   // cycle (after start edge) in which done is high
    bit       pass;
    int       fail;
    bit [1:0] ffv;
    bit       ffvalid;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_start(input bit c1, input bit [2:0] op);
    @(negedge clk);
    cur1 = c1;
    bus2.i_gate_op = op;
    bus1.i_gate_op = op;
    if (c1) bus1.i_start = 1'b1; else bus2.i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.i_start = 1'b0;
    bus2.i_start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    int per;
    mode2 = v.mode;
    per   = v.cfg1 ? 2 : 3;
    do_start(v.cfg1, v.op);
    cyc = 1;
    chk("busy_after_start", int'(w_busy), 1);
    chk("stim_first", int'(w_stim), 0);
    while (!w_done) begin
      if (cyc >= 60) begin
        chk("done_timeout", cyc, v.cycles);
        break;
      end
      @(negedge clk);
      cyc++;
      if (w_busy && ((cyc - 1) % per == 0))
        chk("stim_seq", int'(w_stim), (cyc - 1) / per);
    end
    chk("done_cycle", cyc, v.cycles);
    chk("pass", int'(w_pass), int'(v.pass));
    chk("fail_count", int'(w_fail), v.fail);
    chk("first_fail_vec", int'(w_ffv), int'(v.ffv));
    chk("first_fail_valid", int'(w_ffvalid), int'(v.ffvalid));
    chk("busy_in_done", int'(w_busy), 0);
    chk("stim_final", int'(w_stim), v.cfg1 ? 1 : 3);
    @(negedge clk);
    chk("done_one_cycle", int'(w_done), 0);
    chk("pass_held", int'(w_pass), int'(v.pass));
    chk("fail_held", int'(w_fail), v.fail);
  endtask

  initial begin
    int ndone, nrise, done1, done2, rise2;
    logic prev_busy;

    //          cfg1 mode op    cyc pass fail ffv    valid
    vecs[0] = '{1'b0, 0, 3'd0, 13, 1'b1, 0, 2'd0, 1'b0}; // NOT, inverter
    vecs[1] = '{1'b0, 1, 3'd2, 13, 1'b0, 2, 2'd1, 1'b1}; // AND vs OR gate
    vecs[2] = '{1'b0, 2, 3'd5, 13, 1'b0, 1, 2'd0, 1'b1}; // NOR vs stuck-0
    vecs[3] = '{1'b0, 0, 3'd4, 13, 1'b0, 1, 2'd1, 1'b1}; // NAND vs inverter
    vecs[4] = '{1'b0, 1, 3'd6, 13, 1'b0, 1, 2'd3, 1'b1}; // XOR vs OR gate
    vecs[5] = '{1'b0, 2, 3'd7, 13, 1'b0, 2, 2'd0, 1'b1}; // XNOR vs stuck-0
    vecs[6] = '{1'b0, 0, 3'd1, 13, 1'b0, 4, 2'd0, 1'b1}; // BUF vs inverter: 2^N_IN
    vecs[7] = '{1'b1, 0, 3'd0,  5, 1'b1, 0, 2'd0, 1'b0}; // N_IN=1 NOT
    vecs[8] = '{1'b1, 0, 3'd1,  5, 1'b0, 2, 2'd0, 1'b1}; // N_IN=1 BUF

    bus2.i_start = 1'b0; bus2.i_gate_op = '0;
    bus1.i_start = 1'b0; bus1.i_gate_op = '0;
    rst2_n = 1'b0; rst1_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stim", int'(bus2.o_stim), 0);
    chk("rst_busy", int'(bus2.o_busy), 0);
    chk("rst_done", int'(bus2.o_done), 0);
    chk("rst_pass", int'(bus2.o_pass), 0);
    chk("rst_fail", int'(bus2.o_fail_count), 0);
    chk("rst_ffvalid", int'(bus2.o_first_fail_valid), 0);
    chk("rst1_fail", int'(bus1.o_fail_count), 0);
    rst2_n = 1'b1; rst1_n = 1'b1;
    @(negedge clk);

    for (int unsigned i = 0; i < 9; i++) run_vec(vecs[i]);

    // start held high for 20 sampling edges: exactly two back-to-back runs
    cur1 = 1'b0; mode2 = 0;
    bus2.i_gate_op = 3'd0;
    bus2.i_start = 1'b1;
    ndone = 0; nrise = 0; done1 = 0; done2 = 0; rise2 = 0;
    prev_busy = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 20) bus2.i_start = 1'b0;
      if (bus2.o_done) begin
        ndone++;
        if (ndone == 1) done1 = c; else done2 = c;
      end
      if (bus2.o_busy && !prev_busy) begin
        nrise++;
        if (nrise == 2) rise2 = c;
      end
      prev_busy = bus2.o_busy;
    end
    chk("held_done_count", ndone, 2);
    chk("held_busy_rises", nrise, 2);
    chk("held_done1_cycle", done1, 13);
    chk("held_restart_cycle", rise2, done1 + 2);
    chk("held_done2_cycle", done2, 27);
    chk("held_pass", int'(bus2.o_pass), 1);

    // asynchronous reset during vector 2
    mode2 = 2;
    do_start(1'b0, 3'd5);
    repeat (7) @(negedge clk);   // cycle 8: stim should be 2
    chk("mid_stim_vec2", int'(bus2.o_stim), 2);
    #2 rst2_n = 1'b0;
    #1;
    chk("abort_stim", int'(bus2.o_stim), 0);
    chk("abort_busy", int'(bus2.o_busy), 0);
    chk("abort_fail", int'(bus2.o_fail_count), 0);
    chk("abort_ffvalid", int'(bus2.o_first_fail_valid), 0);
    chk("abort_ffv", int'(bus2.o_first_fail_vec), 0);
    ndone = 0;
    repeat (2) @(negedge clk);
    rst2_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus2.o_done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Self-checking built-in test controller for the single-output combinational gates in the lab library (inverter, AND/OR/NAND/NOR/XOR/XNOR, buffer). It drives every input vector onto a gate under test and waits a programmable settle time. It then compares the gate output against the expected function and reports pass/fail with a mismatch count and the first failing vector. It replaces hand-written per-gate stimulus benches and sits between a top-level test harness and one gate instance.

## Interface
- N_IN, 2, number of gate inputs; legal range 1..4
- SETTLE, 2, cycles a vector is held before the output is sampled; legal range 1..15
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a test run; sampled only in IDLE
- gate_op  in  3  expected function, captured at start: 0 NOT, 1 BUF, 2 AND, 3 OR, 4 NAND, 5 NOR, 6 XOR, 7 XNOR
- dut_out  in  1  output of the gate under test
- stim  out  N_IN  registered input vector driven to the gate under test
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the run completes
- pass  out  1  valid after done; 1 if fail_count == 0; held until next start
- fail_count  out  N_IN+1  number of mismatching vectors; held until next start
- first_fail_vec  out  N_IN  stim value of the first mismatch; 0 if none
- first_fail_valid  out  1  high once any mismatch has been recorded in the current run

## Operation
- Reset values (async, rst_n low): state IDLE, stim 0, busy 0, done 0, pass 0, fail_count 0, first_fail_vec 0, first_fail_valid 0, settle counter 0.
- States: IDLE, WAIT, CHECK, DONE.
- IDLE:
  - busy 0.
  - start=1 → capture gate_op into op_q; clear fail_count, first_fail_vec, first_fail_valid and pass; stim←0; cnt←SETTLE-1; go to WAIT.
- WAIT: cnt==0 → CHECK; otherwise cnt←cnt-1. stim is stable throughout.
- CHECK:
  - expected = f(op_q, stim).
  - NOT/BUF use stim[0] only.
  - AND/OR/XOR and their complements are reductions over all N_IN bits.
  - dut_out≠expected → fail_count+1. If first_fail_valid is 0, also load first_fail_vec←stim and set first_fail_valid.
  - stim == all-ones → DONE.
  - Otherwise stim←stim+1, cnt←SETTLE-1, back to WAIT.
- DONE: done=1 for this cycle; pass←(final fail_count==0), including any mismatch found in the last CHECK; busy 0; go to IDLE next cycle.
- start is ignored in WAIT, CHECK and DONE. A start held high through DONE is accepted on the following IDLE cycle.
- stim is not returned to 0 after a run; it holds all-ones until the next start or reset.
- fail_count width N_IN+1 holds 2^N_IN without saturation or wrap.
- rst_n asserted mid-run: immediate abort to reset values; no done pulse; the next run starts from vector 0.

## Timing
- start sampled high at edge E0 → stim=0 and busy=1 visible after E0.
- Each vector occupies SETTLE WAIT cycles plus 1 CHECK cycle. dut_out is sampled on the CHECK edge, SETTLE+1 edges after stim changed.
- Run length: 2^N_IN × (SETTLE+1) cycles after E0. The done pulse occupies the next cycle; pass, fail_count and first_fail_* are final in that cycle.
- Example: N_IN=2, SETTLE=2 → 12 cycles, with done high in cycle 13 after E0.
- Minimum restart interval: a start in the cycle after DONE is accepted.

## Test plan
- N_IN=2, SETTLE=2, behavioural inverter on stim[0], gate_op=0 → done 13 cycles after start; pass=1, fail_count=0, first_fail_valid=0; stim sequence 0,1,2,3.
- gate_op=2 (AND) with DUT wired as OR → fail_count=2, first_fail_vec=2'b01, first_fail_valid=1, pass=0.
- gate_op=5 (NOR) with DUT output stuck at 0 → fail_count=1, first_fail_vec=2'b00, pass=0.
- N_IN=1, SETTLE=1, inverter DUT, gate_op=0 → done 5 cycles after start, pass=1. Rerun with gate_op=1 → fail_count=2, first_fail_vec=0.
- start held high for 20 cycles → exactly two runs; the second begins the cycle after the first done; no start is accepted while busy=1.
- rst_n pulsed low during vector 2 → all outputs 0 within the same cycle, no done. A new start gives a full clean run with pass=1 on a correct DUT.
